// File: rtl/imem_responder_pkg.sv
// Shared types and constants for the instruction-memory responder.
// IMEM_WAIT_EN adds the WAIT state to the FSM encoding.
package imem_responder_pkg;

  localparam int unsigned BUNDLE_W = 64;
  localparam logic [BUNDLE_W-1:0] NOP_BUNDLE = 64'h00000013_00000013;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
`ifdef IMEM_WAIT_EN
    WAIT = 3'd1,
`endif
    RD0  = 3'd2,
    RD1  = 3'd3,
    RESP = 3'd4
  } fsmState_t;

  // Pick the 64-bit window starting at halfword halfOff of the {hi,lo} pair.
  function automatic logic [BUNDLE_W-1:0] bundleSelect(
    input logic [BUNDLE_W-1:0] hiWord,
    input logic [BUNDLE_W-1:0] loWord,
    input logic [1:0]          halfOff
  );
    logic [2*BUNDLE_W-1:0] pair;
    pair = {hiWord, loWord} >> {halfOff, 4'b0000};
    return pair[BUNDLE_W-1:0];
  endfunction

endpackage

// File: rtl/imem_responder_if.sv
// Fetch request / instruction response channel between fetch unit and imem.
interface imem_responder_if;
  import imem_responder_pkg::*;

  logic                Fetch_ReqValid;
  logic                Fetch_ReqReady;
  logic [31:0]         Fetch_ReqAddr;
  logic                Imem_RspValid;
  logic                Imem_RspReady;
  logic [BUNDLE_W-1:0] Imem_RspInstr;
  logic [31:0]         Imem_RspAddr;
  logic                Imem_RspErr;
  logic                Imem_Flush;

  modport master (
    output Fetch_ReqValid, Fetch_ReqAddr, Imem_RspReady, Imem_Flush,
    input  Fetch_ReqReady, Imem_RspValid, Imem_RspInstr, Imem_RspAddr, Imem_RspErr
  );

  modport slave (
    input  Fetch_ReqValid, Fetch_ReqAddr, Imem_RspReady, Imem_Flush,
    output Fetch_ReqReady, Imem_RspValid, Imem_RspInstr, Imem_RspAddr, Imem_RspErr
  );

endinterface

// File: rtl/imem_responder_ram.sv
// DEPTH_WORDS x 64 synchronous-read RAM with a preload write port.
module imem_ram
  import imem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           wrEn,
  input  logic [$clog2(DEPTH_WORDS)-1:0] wrAddr,
  input  logic [BUNDLE_W-1:0]            wrData,
  input  logic [$clog2(DEPTH_WORDS)-1:0] rdAddr,
  output logic [BUNDLE_W-1:0]            rdData
);

  logic [BUNDLE_W-1:0] mem [DEPTH_WORDS];

  // Read and write on the same edge: a colliding read sees the old word.
  always_ff @(posedge clk) begin
    if (wrEn) mem[wrAddr] <= wrData;
    rdData <= mem[rdAddr];
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction memory responder: one 64-bit fetch bundle per request, any halfword alignment.
// Define IMEM_WAIT_EN to insert WAIT_CYCLES wait states before the RAM read.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  imem_responder_if.slave                bus,
  input  logic                           Load_En,
  input  logic [$clog2(DEPTH_WORDS)-1:0] Load_Addr,
  input  logic [BUNDLE_W-1:0]            Load_Data
);

  localparam int unsigned   AW        = $clog2(DEPTH_WORDS);
  localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH_WORDS - 1);

  fsmState_t           state;
  logic [31:0]         reqAddr;
  logic [1:0]          halfOff;
  logic [AW-1:0]       wordIdx;
  logic [AW-1:0]       rdAddr;
  logic [BUNDLE_W-1:0] rdData;
  logic [BUNDLE_W-1:0] loWord;
  logic                rspValid;
  logic [BUNDLE_W-1:0] rspInstr;
  logic [31:0]         rspAddr;
  logic                rspErr;
  logic [31:0]         reqOff;
  logic [31:0]         reqWord;
  logic                reqErr;
`ifdef IMEM_WAIT_EN
  logic [31:0]         waitCnt;
`endif

  always_comb begin
    reqOff  = bus.Fetch_ReqAddr - BASE_ADDR;
    reqWord = reqOff >> 3;
    reqErr  = bus.Fetch_ReqAddr[0] || (bus.Fetch_ReqAddr < BASE_ADDR) ||
              (reqWord >= 32'(DEPTH_WORDS));
  end

  assign rdAddr = (state == RD1) ? ((wordIdx == LAST_WORD) ? '0 : wordIdx + AW'(1)) : wordIdx;

  assign bus.Fetch_ReqReady = (state == IDLE) && !rst && !bus.Imem_Flush;
  assign bus.Imem_RspValid  = rspValid;
  assign bus.Imem_RspInstr  = rspInstr;
  assign bus.Imem_RspAddr   = rspAddr;
  assign bus.Imem_RspErr    = rspErr;

  imem_ram #(.DEPTH_WORDS(DEPTH_WORDS)) uRam (
    .clk    (clk),
    .wrEn   (Load_En),
    .wrAddr (Load_Addr),
    .wrData (Load_Data),
    .rdAddr (rdAddr),
    .rdData (rdData)
  );

  // RESP with rspValid low is the cycle where the last RAM word lands and is latched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rspValid <= 1'b0;
      rspInstr <= NOP_BUNDLE;
      rspAddr  <= '0;
      rspErr   <= 1'b0;
      reqAddr  <= '0;
      halfOff  <= '0;
      wordIdx  <= '0;
      loWord   <= '0;
`ifdef IMEM_WAIT_EN
      waitCnt  <= '0;
`endif
    end else if (bus.Imem_Flush) begin
      state    <= IDLE;
      rspValid <= 1'b0;
`ifdef IMEM_WAIT_EN
      waitCnt  <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.Fetch_ReqValid) begin
            reqAddr <= bus.Fetch_ReqAddr;
            halfOff <= bus.Fetch_ReqAddr[2:1];
            wordIdx <= reqWord[AW-1:0];
            if (reqErr) begin
              state    <= RESP;
              rspValid <= 1'b1;
              rspErr   <= 1'b1;
              rspInstr <= NOP_BUNDLE;
              rspAddr  <= bus.Fetch_ReqAddr;
            end else begin
`ifdef IMEM_WAIT_EN
              state <= (WAIT_CYCLES > 0) ? WAIT : RD0;
`else
              state <= RD0;
`endif
            end
          end
        end
`ifdef IMEM_WAIT_EN
        WAIT: begin
          if (waitCnt == 32'(WAIT_CYCLES - 1)) begin
            waitCnt <= '0;
            state   <= RD0;
          end else begin
            waitCnt <= waitCnt + 32'd1;
          end
        end
`endif
        RD0: state <= (halfOff != 2'd0) ? RD1 : RESP;
        RD1: begin
          loWord <= rdData;
          state  <= RESP;
        end
        RESP: begin
          if (!rspValid) begin
            rspValid <= 1'b1;
            rspErr   <= 1'b0;
            rspAddr  <= reqAddr;
            rspInstr <= (halfOff == 2'd0) ? rdData : bundleSelect(rdData, loWord, halfOff);
          end else if (bus.Imem_RspReady) begin
            rspValid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: halfword-level memory model, randomized fetches, directed corners.
module tb_imem_responder;
  import imem_responder_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned WAITC = 2;
  localparam logic [63:0] NOP   = 64'h00000013_00000013;
`ifdef IMEM_WAIT_EN
  localparam int WAIT_EXTRA = WAITC;
`else
  localparam int WAIT_EXTRA = 0;
`endif

  typedef struct {
    logic [63:0] instr;
    logic [31:0] addr;
    logic        err;
    int          due;
  } expT;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          loadEn = 1'b0;
  logic [AW-1:0] loadAddr = '0;
  logic [63:0]   loadData = '0;

  imem_responder_if bus();

  imem_responder #(
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (32'h0000_0000),
    .WAIT_CYCLES (WAITC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .Load_En   (loadEn),
    .Load_Addr (loadAddr),
    .Load_Data (loadData)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] model [DEPTH];
  expT         expQ [$];
  expT         cur;
  bit          active = 1'b0;
  bit          abortPending = 1'b0;
  bit          holdMode = 1'b0;
  int          checks = 0;
  int          passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic noteFail(input string name);
    checks++;
    $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
  endtask

  // Memory viewed as a flat halfword array; a bundle is 4 consecutive halfwords, wrapping.
  function automatic expT predict(input logic [31:0] a, input int acc);
    expT         e;
    int unsigned h;
    int unsigned idx;
    logic [63:0] w;
    e.addr  = a;
    e.instr = '0;
    if (a[0] || a >= 32'(DEPTH * 8)) begin
      e.err   = 1'b1;
      e.instr = NOP;
      e.due   = acc;
    end else begin
      e.err = 1'b0;
      h = a / 2;
      for (int k = 0; k < 4; k++) begin
        idx = (h + k) % (DEPTH * 4);
        w   = model[idx / 4];
        e.instr[16*k +: 16] = w[16*(idx % 4) +: 16];
      end
      e.due = acc + ((a[2:1] != 2'd0) ? 4 : 3) - 1 + WAIT_EXTRA;
    end
    return e;
  endfunction

  always @(posedge clk) begin
    #2;
    bus.Imem_RspReady = holdMode ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk) begin
    if (rst) begin
      active = 1'b0;
    end else if (bus.Imem_RspValid) begin
      if (!active) begin
        if (expQ.size() == 0) begin
          noteFail("spuriousRsp");
        end else begin
          cur    = expQ.pop_front();
          active = 1'b1;
          chk("latency", 64'(cyc), 64'(cur.due));
        end
      end
      if (active) begin
        chk("rspInstr", bus.Imem_RspInstr, cur.instr);
        chk("rspAddr", 64'(bus.Imem_RspAddr), 64'(cur.addr));
        chk("rspErr", 64'(bus.Imem_RspErr), 64'(cur.err));
        if (bus.Imem_RspReady) active = 1'b0;
      end
    end else if (active) begin
      if (!abortPending) noteFail("rspDropped");
      active = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

  task automatic load(input int unsigned idx, input logic [63:0] d);
    loadEn   = 1'b1;
    loadAddr = AW'(idx);
    loadData = d;
    @(posedge clk); #1;
    loadEn     = 1'b0;
    model[idx] = d;
  endtask

  task automatic fetch(input logic [31:0] a);
    bit   got;
    logic r;
    got = 1'b0;
    bus.Fetch_ReqValid = 1'b1;
    bus.Fetch_ReqAddr  = a;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      r = bus.Fetch_ReqReady;
      @(posedge clk); #1;
      got = r;
    end
    bus.Fetch_ReqValid = 1'b0;
    if (got) expQ.push_back(predict(a, cyc));
    else noteFail("acceptTimeout");
  endtask

  task automatic waitIdle();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      done = bus.Fetch_ReqReady && !bus.Imem_RspValid && (expQ.size() == 0);
    end
    if (!done) noteFail("idleTimeout");
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] randAddr();
    case ($urandom_range(0, 7))
      0:       return 32'($urandom_range(0, DEPTH * 8 - 1)) | 32'd1;
      1:       return 32'(DEPTH * 8) + 32'($urandom_range(0, 255));
      2:       return 32'((DEPTH - 1) * 8) + 32'(2 * $urandom_range(0, 3));
      default: return 32'($urandom_range(0, DEPTH * 8 - 1)) & ~32'd1;
    endcase
  endfunction

  initial begin
    expT  dropped;
    int   seen;
    bus.Fetch_ReqValid = 1'b0;
    bus.Fetch_ReqAddr  = '0;
    bus.Imem_Flush     = 1'b0;
    bus.Imem_RspReady  = 1'b0;

    // Outputs while reset is held
    repeat (2) @(negedge clk);
    chk("rstReqReady", 64'(bus.Fetch_ReqReady), 64'd0);
    chk("rstRspValid", 64'(bus.Imem_RspValid), 64'd0);
    chk("rstRspInstr", bus.Imem_RspInstr, NOP);
    chk("rstRspAddr", 64'(bus.Imem_RspAddr), 64'd0);
    chk("rstRspErr", 64'(bus.Imem_RspErr), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int unsigned i = 0; i < DEPTH; i++) load(i, {$urandom, $urandom});
    load(0, 64'h11112222_33334444);
    load(1, 64'hAAAABBBB_CCCCDDDD);

    // Aligned, unaligned, misaligned, out of range, last-word wrap
    fetch(32'd0);
    fetch(32'd2);
    fetch(32'd1);
    fetch(32'(DEPTH * 8));
    fetch(32'((DEPTH - 1) * 8 + 4));
    fetch(32'((DEPTH - 1) * 8 + 6));
    waitIdle();

    // Load to the word under read in RD0 returns the old contents
    fetch(32'd40);
    repeat (WAIT_EXTRA) begin @(posedge clk); #1; end
    load(5, 64'hFEDCBA98_76543210);
    waitIdle();
    fetch(32'd40);
    waitIdle();

    // Flush while in RD1
    fetch(32'd18);
    repeat (WAIT_EXTRA) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    abortPending = 1'b1;
    bus.Imem_Flush = 1'b1;
    dropped = expQ.pop_back();
    @(posedge clk); #1;
    bus.Imem_Flush = 1'b0;
    @(negedge clk);
    chk("flushRd1Ready", 64'(bus.Fetch_ReqReady), 64'd1);
    chk("flushRd1Valid", 64'(bus.Imem_RspValid), 64'd0);
    repeat (6) @(posedge clk); #1;
    abortPending = 1'b0;

    // Flush together with a request in IDLE
    waitIdle();
    bus.Fetch_ReqValid = 1'b1;
    bus.Fetch_ReqAddr  = 32'd8;
    bus.Imem_Flush     = 1'b1;
    @(posedge clk); #1;
    bus.Fetch_ReqValid = 1'b0;
    bus.Imem_Flush     = 1'b0;
    @(negedge clk);
    chk("flushIdleReady", 64'(bus.Fetch_ReqReady), 64'd1);
    chk("flushIdleValid", 64'(bus.Imem_RspValid), 64'd0);
    repeat (6) @(posedge clk); #1;

    // Response held for 5 cycles with RspReady low
    waitIdle();
    holdMode = 1'b1;
    fetch(32'd8);
    for (int n = 0; n < 20 && !bus.Imem_RspValid; n++) @(negedge clk);
    seen = 0;
    repeat (5) begin
      if (bus.Imem_RspValid) seen++;
      @(negedge clk);
    end
    chk("holdCycles", 64'(seen), 64'd5);
    chk("holdStillValid", 64'(bus.Imem_RspValid), 64'd1);
    holdMode = 1'b0;
    @(posedge clk); #1;
    waitIdle();

    // Reset asserted while in RD0
    fetch(32'd24);
    repeat (WAIT_EXTRA) begin @(posedge clk); #1; end
    abortPending = 1'b1;
    expQ.delete();
    rst = 1'b1;
    @(negedge clk);
    chk("midRstReqReady", 64'(bus.Fetch_ReqReady), 64'd0);
    chk("midRstRspValid", 64'(bus.Imem_RspValid), 64'd0);
    chk("midRstRspInstr", bus.Imem_RspInstr, NOP);
    chk("midRstRspAddr", 64'(bus.Imem_RspAddr), 64'd0);
    chk("midRstRspErr", 64'(bus.Imem_RspErr), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(posedge clk); #1;
    abortPending = 1'b0;

    // Randomized traffic with occasional reloads between fetches
    for (int t = 0; t < 150; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        waitIdle();
        load($urandom_range(0, DEPTH - 1), {$urandom, $urandom});
      end
      fetch(randAddr());
    end

    waitIdle();
    chk("queueDrained", 64'(expQ.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
